// File: rtl/rr_sched_fsm.sv
// rr_sched_fsm: three-way scheduler for a shared 5-bit operand path.
// One requester owns the path for a burst of at most MAX_HOLD cycles. Every
// burst is followed by a single DRAIN cycle, after which the block re-arbitrates.
// Build option: define ROUND_ROBIN_EN for rotating priority. When it is left
// undefined, priority is fixed with req[0] highest and req[2] lowest.
module rr_sched_fsm #(
   parameter int unsigned MAX_HOLD = 4  // legal range 1..8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic [4:0] a,
   input  logic [4:0] b,
   input  logic [4:0] c,
   output logic [2:0] gnt,
   output logic [4:0] dout,
   output logic       busy
);

   // State codes are fixed. Codes 0 and 6..15 are deliberately left unused.
   typedef enum logic [3:0] {
      StIdle  = 4'd1,
      StG0    = 4'd2,
      StG1    = 4'd3,
      StG2    = 4'd4,
      StDrain = 4'd5
   } state_e;

   // The last cycle of a burst, expressed as a counter value.
   localparam logic [2:0] HoldLast = 3'(MAX_HOLD - 1);

   // The register is plain logic rather than state_e. This lets it hold and
   // recover from the unused codes.
   logic [3:0] state_q;
   logic [2:0] gnt_q;
   logic [2:0] cnt_q;
   logic [1:0] last_q;

   logic [1:0] win;
   logic       win_any;
   logic [1:0] own;
   logic       hold_done;

`ifdef ROUND_ROBIN_EN
   logic [1:0] start;
   logic [1:0] cand;

   // Returns (base + off) mod 3 for operands in the range 0..2.
   function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] off);
      logic [2:0] s;
      s = {1'b0, base} + {1'b0, off};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   // Rotating priority: scan upward from the slot after the most recent owner.
   always_comb begin
      win_any = |req;
      win     = 2'd0;
      cand    = 2'd0;
      unique case (last_q)
         2'd0:    start = 2'd1;
         2'd1:    start = 2'd2;
         default: start = 2'd0;
      endcase
      // The scan runs from the highest offset down, so the nearest set bit wins.
      for (int k = 2; k >= 0; k--) begin
         cand = wrap3(start, 2'(k));
         if (req[cand]) begin
            win = cand;
         end
      end
   end
`else
   // Fixed priority: req[0] beats req[1], which beats req[2].
   always_comb begin
      win_any = |req;
      if (req[0]) begin
         win = 2'd0;
      end else if (req[1]) begin
         win = 2'd1;
      end else begin
         win = 2'd2;
      end
   end
`endif

   // Find the current owner index from the grant state, and detect burst expiry.
   always_comb begin
      unique case (state_q)
         StG1:    own = 2'd1;
         StG2:    own = 2'd2;
         default: own = 2'd0;
      endcase
      hold_done = (cnt_q == HoldLast);
   end

   // Single FSM register block. It updates state, grant, hold count and last owner.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         gnt_q   <= 3'b000;
         cnt_q   <= 3'd0;
         last_q  <= 2'd2;
      end else begin
         case (state_q)
            StIdle, StDrain: begin
               if (win_any) begin
                  unique case (win)
                     2'd0:    state_q <= StG0;
                     2'd1:    state_q <= StG1;
                     default: state_q <= StG2;
                  endcase
                  gnt_q  <= 3'b001 << win;
                  cnt_q  <= 3'd0;
                  last_q <= win;
               end else begin
                  state_q <= StIdle;
                  gnt_q   <= 3'b000;
                  cnt_q   <= 3'd0;
               end
            end
            StG0, StG1, StG2: begin
               // A dropped request and an expired hold both lead to the same
               // single DRAIN cycle.
               if (!req[own] || hold_done) begin
                  state_q <= StDrain;
                  gnt_q   <= 3'b000;
                  cnt_q   <= 3'd0;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            default: begin
               // Recovery path for an unused state code.
               state_q <= StIdle;
               gnt_q   <= 3'b000;
               cnt_q   <= 3'd0;
            end
         endcase
      end
   end

   // Drive the shared path from the registered grant. The output is 0 when
   // there is no owner.
   always_comb begin
      unique case (gnt_q)
         3'b001:  dout = a;
         3'b010:  dout = b;
         3'b100:  dout = c;
         default: dout = 5'd0;
      endcase
      busy = (state_q == StG0) || (state_q == StG1) || (state_q == StG2);
   end

   assign gnt = gnt_q;

   // Structural invariants: the grant is at most one-hot, the counter stays
   // within the burst, and the last pointer never takes code 3.
   a_gnt_onehot : assert property (@(posedge clk) $onehot0(gnt_q));
   a_cnt_bound  : assert property (@(posedge clk) cnt_q <= HoldLast);
   a_last_range : assert property (@(posedge clk) last_q != 2'd3);

endmodule

// File: tb/tb_rr_sched_fsm.sv
// Self-checking bench for rr_sched_fsm.
// Two instances share the same stimulus: dut4 uses MAX_HOLD=4 and dut2 uses
// MAX_HOLD=2. Directed table rows and hand-written sequences run first. A
// randomized run then checks both instances against an owner/burst-length
// reference model.
module tb_rr_sched_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req;
   logic [4:0] a, b, c;
   logic [2:0] gnt4, gnt2;
   logic [4:0] dout4, dout2;
   logic       busy4, busy2;

   int checks   = 0;
   int failures = 0;

`ifdef ROUND_ROBIN_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   always #5 clk = ~clk;

   rr_sched_fsm #(.MAX_HOLD(4)) dut4 (
      .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c),
      .gnt(gnt4), .dout(dout4), .busy(busy4)
   );

   rr_sched_fsm #(.MAX_HOLD(2)) dut2 (
      .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c),
      .gnt(gnt2), .dout(dout2), .busy(busy2)
   );

   // Reference model: owner index (-1 means none), grant cycles used, last owner.
   int m_owner[2];
   int m_len[2];
   int m_last[2];

   function automatic int mh_of(input int k);
      return (k == 0) ? 4 : 2;
   endfunction

   function automatic logic [4:0] sel(input logic [2:0] g);
      case (g)
         3'b001:  return a;
         3'b010:  return b;
         3'b100:  return c;
         default: return 5'd0;
      endcase
   endfunction

   function automatic logic [2:0] m_gnt(input int k);
      return (m_owner[k] < 0) ? 3'b000 : 3'(3'b001 << m_owner[k]);
   endfunction

   task automatic model_step(input int k);
      if (!rst) begin
         m_owner[k] = -1;
         m_len[k]   = 0;
         m_last[k]  = 2;
      end else if (m_owner[k] >= 0) begin
         if (!req[2'(m_owner[k])] || m_len[k] >= mh_of(k)) begin
            m_owner[k] = -1;
            m_len[k]   = 0;
         end else begin
            m_len[k]++;
         end
      end else if (req != 3'b000) begin
         int  first;
         bit  found;
         first = RrEn ? (m_last[k] + 1) % 3 : 0;
         found = 1'b0;
         for (int j = 0; j < 3; j++) begin
            int idx;
            idx = (first + j) % 3;
            if (!found && req[2'(idx)]) begin
               found      = 1'b1;
               m_owner[k] = idx;
               m_len[k]   = 1;
               m_last[k]  = idx;
            end
         end
      end
   endtask

   // Advance the models and then the DUTs by one edge. Outputs are sampled 1 ns later.
   task automatic tick();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("rand_gnt4", 32'(gnt4), 32'(m_gnt(0)));
      check("rand_dout4", 32'(dout4), 32'(sel(m_gnt(0))));
      check("rand_busy4", 32'(busy4), 32'(m_owner[0] >= 0));
      check("rand_gnt2", 32'(gnt2), 32'(m_gnt(1)));
      check("rand_dout2", 32'(dout2), 32'(sel(m_gnt(1))));
      check("rand_busy2", 32'(busy2), 32'(m_owner[1] >= 0));
   endtask

   typedef struct {
      bit         rst;
      logic [2:0] req;
      logic [2:0] g4;
      logic [2:0] g2;
   } vec_t;

   vec_t       tbl[8];
   logic [2:0] rot_exp[10];

   initial begin
      rst = 1'b0;
      req = 3'b000;
      a   = 5'd9;
      b   = 5'd3;
      c   = 5'd17;

      // Reset with all requests high, then req0 bursts. Expected grant per edge.
      tbl[0] = '{1'b0, 3'b111, 3'b000, 3'b000};
      tbl[1] = '{1'b0, 3'b111, 3'b000, 3'b000};
      tbl[2] = '{1'b1, 3'b111, 3'b001, 3'b001};
      tbl[3] = '{1'b1, 3'b001, 3'b001, 3'b001};
      tbl[4] = '{1'b1, 3'b001, 3'b001, 3'b000};
      tbl[5] = '{1'b1, 3'b001, 3'b001, 3'b001};
      tbl[6] = '{1'b1, 3'b001, 3'b000, 3'b001};
      tbl[7] = '{1'b1, 3'b001, 3'b001, 3'b000};
      for (int i = 0; i < 8; i++) begin
         rst = tbl[i].rst;
         req = tbl[i].req;
         tick();
         check($sformatf("tbl%0d_gnt4", i), 32'(gnt4), 32'(tbl[i].g4));
         check($sformatf("tbl%0d_dout4", i), 32'(dout4), 32'(sel(tbl[i].g4)));
         check($sformatf("tbl%0d_busy4", i), 32'(busy4), 32'(tbl[i].g4 != 3'b000));
         check($sformatf("tbl%0d_gnt2", i), 32'(gnt2), 32'(tbl[i].g2));
      end

      // Constant req=111 on dut2: rotation, or starvation under fixed priority.
`ifdef ROUND_ROBIN_EN
      rot_exp = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000,
                  3'b100, 3'b100, 3'b000, 3'b001};
`else
      rot_exp = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000,
                  3'b001, 3'b001, 3'b000, 3'b001};
`endif
      a = 5'd9; b = 5'd21; c = 5'd30;
      rst = 1'b0; tick();
      rst = 1'b1; req = 3'b111;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("rot%0d_gnt2", i), 32'(gnt2), 32'(rot_exp[i]));
         check($sformatf("rot%0d_dout2", i), 32'(dout2), 32'(sel(rot_exp[i])));
      end

      // Early release on dut4: req0 drops after 2 grant cycles while req2 waits.
      rst = 1'b0; tick();
      rst = 1'b1; req = 3'b101;
      tick(); check("early_g1", 32'(gnt4), 32'(3'b001));
      tick(); check("early_g2", 32'(gnt4), 32'(3'b001));
      req = 3'b100;
      tick(); check("early_drain", 32'(gnt4), 32'(3'b000));
      tick(); check("early_next", 32'(gnt4), 32'(3'b100));

      // Drop coincides with the last hold cycle: a single DRAIN cycle.
      rst = 1'b0; tick();
      rst = 1'b1; req = 3'b101;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("simul_g%0d", i), 32'(gnt4), 32'(3'b001));
      end
      req = 3'b100;
      tick(); check("simul_drain", 32'(gnt4), 32'(3'b000));
      check("simul_drain_busy", 32'(busy4), 32'd0);
      tick(); check("simul_next", 32'(gnt4), 32'(3'b100));

      // Reset asserted during G1 with cnt=2.
      rst = 1'b0; tick();
      rst = 1'b1; req = 3'b010;
      tick(); tick(); tick();
      check("mid_cnt_pre", 32'(dut4.cnt_q), 32'd2);
      check("mid_gnt_pre", 32'(gnt4), 32'(3'b010));
      rst = 1'b0; tick();
      check("mid_gnt", 32'(gnt4), 32'd0);
      check("mid_state", 32'(dut4.state_q), 32'd1);
      check("mid_cnt", 32'(dut4.cnt_q), 32'd0);
      check("mid_last", 32'(dut4.last_q), 32'd2);
      check("mid_busy", 32'(busy4), 32'd0);
      check("mid_dout", 32'(dout4), 32'd0);

      // Unused state code 7 returns to IDLE with no grant.
      rst = 1'b1; req = 3'b010;
      tick(); check("force_pre", 32'(gnt4), 32'(3'b010));
      force dut4.state_q = 4'd7;
      tick(); check("force_gnt", 32'(gnt4), 32'd0);
      release dut4.state_q;
      req = 3'b000;
      tick(); check("force_state", 32'(dut4.state_q), 32'd1);
      req = 3'b010;
      tick(); check("force_regrant", 32'(gnt4), 32'(3'b010));

      // Randomized run against the reference model. Request bits are sticky so
      // that long bursts occur.
      rst = 1'b0; req = 3'b000; tick();
      rst = 1'b1;
      for (int i = 0; i < 600; i++) begin
         for (int j = 0; j < 3; j++) begin
            if ($urandom_range(0, 3) == 0) req[j] = ~req[j];
         end
         a   = 5'($urandom);
         b   = 5'($urandom);
         c   = 5'($urandom);
         rst = ($urandom_range(0, 63) != 0);
         tick();
         check_model();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_sched_fsm.md
# rr_sched_fsm

Round-robin scheduler that shares one 5-bit operand path between three requesters. Each requester presents a 5-bit operand and a request. The block grants the path to one requester at a time for a bounded burst, inserts a one-cycle drain gap, and then re-arbitrates. It sits in front of the x/y/z register-update datapaths in the FSM test suite. Its state register is explicitly encoded with unreachable codes so that FSM extraction and recovery can be exercised.

## Interface
- MAX_HOLD, 4: maximum consecutive grant cycles per burst; legal range 1..8.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- req  in  3  request bits; bit i belongs to requester i.
- a  in  5  operand of requester 0.
- b  in  5  operand of requester 1.
- c  in  5  operand of requester 2.
- gnt  out  3  registered one-hot grant; 0 when no owner.
- dout  out  5  shared path output: a, b or c selected by gnt; 0 when gnt==0 (combinational from gnt).
- busy  out  1  high when state is G0, G1 or G2.

## Operation
- State register is 4 bits with these codes: IDLE=1, G0=2, G1=3, G2=4, DRAIN=5.
- Codes 0 and 6..15 are unreachable. If one is entered, next state is IDLE, gnt=0 and cnt=0.
- Hold counter cnt is 3 bits.
- Pointer last is 2 bits and records the index of the most recent owner.
- Arbitration happens in IDLE and DRAIN:
  - if req!=0, go to Gw, where w is the winner; set gnt=1<<w, cnt=0, last=w;
  - else go to (or stay in) IDLE.
- Winner selection: scan from (last+1) mod 3 upward with wrap, and pick the first set req bit.
- In Gi, each cycle:
  - if req[i]==0 or cnt==MAX_HOLD-1, go to DRAIN with gnt=0;
  - else cnt<=cnt+1 and stay in Gi.
- Req drop and hold expiry in the same cycle give a single transition to DRAIN.
- DRAIN always lasts exactly one cycle, with gnt=0.
- Requests on non-owner bits during a grant are ignored until the next arbitration point. No preemption.
- Reset values (rst==0 at an edge): state=IDLE, gnt=0, cnt=0, last=2, busy=0, and therefore dout=0.
- Reset mid-burst overrides everything and takes effect at that edge.

## Timing
- Request-to-grant latency: req sampled at edge N while in IDLE or DRAIN gives gnt valid after edge N.
- Burst length is min(cycles req[i] stays high, MAX_HOLD) cycles of gnt.
- Owner releases when req[i] is sampled low at edge M: gnt=0 after edge M.
- Gap between consecutive grants is exactly 1 cycle (the DRAIN cycle).
- dout follows gnt and the live operand inputs within the same cycle; it has no extra latency.
- With MAX_HOLD=1, every burst is one cycle, so a continuously requesting set alternates grant/drain.
- The counter never exceeds MAX_HOLD-1. With MAX_HOLD=8 it reaches 7 and does not wrap.

## Configuration
- ROUND_ROBIN_EN defined: rotating priority as above, with last updated on every grant.
- ROUND_ROBIN_EN undefined: fixed priority, req[0] > req[1] > req[2].
  - last is still maintained but ignored by selection.
  - All other behaviour is identical.

## Test plan
- Reset: hold rst=0 for 2 cycles with req=3'b111 -> gnt=0, dout=0, busy=0. Release rst -> gnt=3'b001 one cycle later, since last=2 makes req0 win.
- Burst limit: MAX_HOLD=4, req=3'b001 held high, a=5'd9 -> gnt=001 and dout=9 for exactly 4 cycles, then 1 cycle gnt=0, then gnt=001 again.
- Rotation (ROUND_ROBIN_EN): req=3'b111 constant, MAX_HOLD=2 -> grant sequence 001,001,0,010,010,0,100,100,0,001, with dout tracking a/b/c.
- Fixed priority (macro undefined): same stimulus -> grant sequence 001,001,0,001,001,0; requesters 1 and 2 are starved.
- Early release: req0 drops after 2 grant cycles while req2 is high -> DRAIN for 1 cycle, then gnt=100. Simultaneous drop with cnt==MAX_HOLD-1 produces a single DRAIN cycle.
- Reset mid-burst: assert rst=0 during G1 with cnt=2 -> after that edge state=IDLE, gnt=0, cnt=0, last=2. Force the state register to code 7 -> IDLE next cycle with gnt=0.
